// File: rtl/execution_stage.sv
// RV64 execute stage: ALU on ID/EX operands, result and forwarded control registered into EX/MEM.
// Latency 1 cycle, captured every edge; no enable and no backpressure (stall/flush handled outside).
module execution_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteEnE,
    input  logic        MemtoRegE,
    input  logic        JALE,
    input  logic        MemReadEnE,
    input  logic        MemWriteEnE,
    input  logic        ALUSrcE,
    input  logic [1:0]  MemSizeE,
    input  logic [1:0]  LoadSizeE,
    input  logic [2:0]  ALUOpE,
    input  logic [2:0]  funct3E,
    input  logic [6:0]  funct7E,
    input  logic [4:0]  RdE,
    input  logic [63:0] PCPlus4E,
    input  logic [63:0] ImmE,
    input  logic [63:0] ReadData1E,
    input  logic [63:0] ReadData2E,
    output logic        RegWriteEnM,
    output logic        MemtoRegM,
    output logic        JALM,
    output logic        MemReadEnM,
    output logic        MemWriteEnM,
    output logic [1:0]  MemSizeM,
    output logic [1:0]  LoadSizeM,
    output logic [4:0]  RdM,
    output logic [63:0] PcPlus4M,
    output logic [63:0] ReadData2M,
    output logic [63:0] ALUResultM
);

    localparam logic [2:0] OP_RTYPE  = 3'b000;
    localparam logic [2:0] OP_ITYPE  = 3'b001;
    localparam logic [2:0] OP_STORE  = 3'b010;
    localparam logic [2:0] OP_JUMP   = 3'b011;
    localparam logic [2:0] OP_LOAD   = 3'b100;
    localparam logic [2:0] OP_BRANCH = 3'b101;
    localparam logic [2:0] OP_LUI    = 3'b111;

    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [31:0] sum32;
    logic [63:0] word_sum;
    logic [63:0] alu_result;

    assign op_a     = ReadData1E;
    assign op_b     = ALUSrcE ? ImmE : ReadData2E;
    // addw/addiw: 32-bit wrap, then sign-extend bit 31
    assign sum32    = op_a[31:0] + op_b[31:0];
    assign word_sum = {{32{sum32[31]}}, sum32};

    always_comb begin
        alu_result = 64'd0;
        case (ALUOpE)
            OP_RTYPE: begin
                case (funct3E)
                    3'd0: alu_result = {63'd0, ($signed(op_a) < $signed(op_b))};
                    3'd1: alu_result = (funct7E == 7'h20) ? word_sum : 64'd0;
                    3'd2: alu_result = op_a >> op_b[5:0];
                    3'd3: alu_result = op_a ^ op_b;
                    3'd4: alu_result = op_a << op_b[5:0];
                    3'd5: alu_result = op_a | op_b;
                    3'd6: alu_result = op_a - op_b;
                    default: alu_result = op_a & op_b;
                endcase
            end
            OP_ITYPE: begin
                case (funct3E)
                    3'd0:    alu_result = word_sum;
                    3'd6:    alu_result = op_a & op_b;
                    3'd7:    alu_result = op_a | op_b;
                    default: alu_result = 64'd0;
                endcase
            end
            OP_STORE, OP_JUMP, OP_LOAD: alu_result = op_a + op_b;
            OP_BRANCH: alu_result = op_a - op_b;
            OP_LUI:    alu_result = ImmE << 12;
            default:   alu_result = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteEnM <= 1'b0;
            MemtoRegM   <= 1'b0;
            JALM        <= 1'b0;
            MemReadEnM  <= 1'b0;
            MemWriteEnM <= 1'b0;
            MemSizeM    <= 2'd0;
            LoadSizeM   <= 2'd0;
            RdM         <= 5'd0;
            PcPlus4M    <= 64'd0;
            ReadData2M  <= 64'd0;
            ALUResultM  <= 64'd0;
        end else begin
            RegWriteEnM <= RegWriteEnE;
            MemtoRegM   <= MemtoRegE;
            JALM        <= JALE;
            MemReadEnM  <= MemReadEnE;
            MemWriteEnM <= MemWriteEnE;
            MemSizeM    <= MemSizeE;
            LoadSizeM   <= LoadSizeE;
            RdM         <= RdE;
            PcPlus4M    <= PCPlus4E;
            // store data is always the register operand, never the immediate
            ReadData2M  <= ReadData2E;
            ALUResultM  <= alu_result;
        end
    end

endmodule

// File: tb/tb_execution_stage.sv
// Directed bench for execution_stage: hand-computed vectors checked 1 ns after each rising edge.
module tb_execution_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEnE, MemtoRegE, JALE, MemReadEnE, MemWriteEnE, ALUSrcE;
    logic [1:0]  MemSizeE, LoadSizeE;
    logic [2:0]  ALUOpE, funct3E;
    logic [6:0]  funct7E;
    logic [4:0]  RdE;
    logic [63:0] PCPlus4E, ImmE, ReadData1E, ReadData2E;
    logic        RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM;
    logic [1:0]  MemSizeM, LoadSizeM;
    logic [4:0]  RdM;
    logic [63:0] PcPlus4M, ReadData2M, ALUResultM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execution_stage dut (
        .clk(clk), .rst(rst),
        .RegWriteEnE(RegWriteEnE), .MemtoRegE(MemtoRegE), .JALE(JALE),
        .MemReadEnE(MemReadEnE), .MemWriteEnE(MemWriteEnE), .ALUSrcE(ALUSrcE),
        .MemSizeE(MemSizeE), .LoadSizeE(LoadSizeE), .ALUOpE(ALUOpE),
        .funct3E(funct3E), .funct7E(funct7E), .RdE(RdE), .PCPlus4E(PCPlus4E),
        .ImmE(ImmE), .ReadData1E(ReadData1E), .ReadData2E(ReadData2E),
        .RegWriteEnM(RegWriteEnM), .MemtoRegM(MemtoRegM), .JALM(JALM),
        .MemReadEnM(MemReadEnM), .MemWriteEnM(MemWriteEnM), .MemSizeM(MemSizeM),
        .LoadSizeM(LoadSizeM), .RdM(RdM), .PcPlus4M(PcPlus4M),
        .ReadData2M(ReadData2M), .ALUResultM(ALUResultM)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        RegWriteEnE = 0; MemtoRegE = 0; JALE = 0; MemReadEnE = 0; MemWriteEnE = 0;
        ALUSrcE = 0; MemSizeE = 0; LoadSizeE = 0; ALUOpE = 0; funct3E = 0; funct7E = 0;
        RdE = 0; PCPlus4E = 0; ImmE = 0; ReadData1E = 0; ReadData2E = 0;
    endtask

    task automatic op(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                      input logic src, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] imm);
        clr();
        ALUOpE = aop; funct3E = f3; funct7E = f7; ALUSrcE = src;
        ReadData1E = a; ReadData2E = b; ImmE = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset held with busy inputs
        rst = 1'b1;
        op(3'b000, 3'd5, 7'h00, 1'b0, 64'hFFFF, 64'hF0F0, 64'h1234);
        RegWriteEnE = 1; MemtoRegE = 1; JALE = 1; MemReadEnE = 1; MemWriteEnE = 1;
        MemSizeE = 2'b11; LoadSizeE = 2'b11; RdE = 5'd31; PCPlus4E = 64'h1000;
        tick(); tick();
        chk("rst_alu", ALUResultM, 64'd0);
        chk("rst_ctrl", {59'd0, RegWriteEnM, MemtoRegM, JALM, MemReadEnM, MemWriteEnM}, 64'd0);
        chk("rst_sizes", {60'd0, MemSizeM, LoadSizeM}, 64'd0);
        chk("rst_rd", {59'd0, RdM}, 64'd0);
        chk("rst_pc", PcPlus4M, 64'd0);
        chk("rst_rd2", ReadData2M, 64'd0);
        rst = 1'b0;

        // I-type
        op(3'b001, 3'd0, 7'h00, 1'b1, 64'd20, 64'd0, 64'd5); RdE = 5'd1; tick();
        chk("addiw", ALUResultM, 64'd25);
        chk("addiw_rd", {59'd0, RdM}, 64'd1);
        op(3'b001, 3'd6, 7'h00, 1'b1, 64'hABCDEF, 64'd0, 64'hFF0F); tick();
        chk("andi", ALUResultM, 64'hCD0F);
        op(3'b001, 3'd7, 7'h00, 1'b1, 64'hA5A5, 64'd0, 64'hF0F0); tick();
        chk("ori", ALUResultM, 64'hF5F5);
        op(3'b001, 3'd0, 7'h00, 1'b1, 64'h7FFFFFFF, 64'd0, 64'd1); tick();
        chk("addiw_ovf", ALUResultM, 64'hFFFFFFFF80000000);
        op(3'b001, 3'd4, 7'h00, 1'b1, 64'h55, 64'd0, 64'h33); tick();
        chk("itype_undef", ALUResultM, 64'd0);

        // R-type, register operand B (immediate set to garbage)
        op(3'b000, 3'd1, 7'h20, 1'b0, 64'd10, 64'd5, 64'hDEAD); tick();
        chk("addw", ALUResultM, 64'd15);
        op(3'b000, 3'd1, 7'h00, 1'b0, 64'd10, 64'd5, 64'hDEAD); tick();
        chk("addw_bad_f7", ALUResultM, 64'd0);
        op(3'b000, 3'd7, 7'h00, 1'b0, 64'hF0F0F0F0F0F0F0F0, 64'h5555AAAA5555AAAA, 64'hDEAD); tick();
        chk("and", ALUResultM, 64'h5050A0A05050A0A0);
        op(3'b000, 3'd3, 7'h00, 1'b0, 64'd1234, 64'd999, 64'hDEAD); tick();
        chk("xor", ALUResultM, 64'd1845);
        op(3'b000, 3'd5, 7'h00, 1'b0, 64'h0F0F, 64'hF000, 64'hDEAD); tick();
        chk("or", ALUResultM, 64'hFF0F);
        op(3'b000, 3'd0, 7'h00, 1'b0, 64'd1, 64'd10, 64'hDEAD); tick();
        chk("slt_1_10", ALUResultM, 64'd1);
        op(3'b000, 3'd0, 7'h00, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'hDEAD); tick();
        chk("slt_m1_1", ALUResultM, 64'd1);
        op(3'b000, 3'd0, 7'h00, 1'b0, 64'd10, 64'd1, 64'hDEAD); tick();
        chk("slt_10_1", ALUResultM, 64'd0);
        op(3'b000, 3'd4, 7'h00, 1'b0, 64'd1, 64'd3, 64'hDEAD); tick();
        chk("sll", ALUResultM, 64'd8);
        op(3'b000, 3'd2, 7'h00, 1'b0, 64'hF0, 64'd4, 64'hDEAD); tick();
        chk("srl", ALUResultM, 64'hF);
        op(3'b000, 3'd2, 7'h00, 1'b0, 64'h8000000000000000, 64'd63, 64'hDEAD); tick();
        chk("srl_logical", ALUResultM, 64'd1);
        op(3'b000, 3'd6, 7'h00, 1'b0, 64'd20, 64'd7, 64'hDEAD); tick();
        chk("sub", ALUResultM, 64'd13);

        // latency: new inputs right after the edge must not show until the next edge
        op(3'b000, 3'd3, 7'h00, 1'b0, 64'd1234, 64'd999, 64'hDEAD);
        @(negedge clk);
        chk("lat_hold", ALUResultM, 64'd13);
        tick();
        chk("lat_update", ALUResultM, 64'd1845);

        // memory / jump
        op(3'b100, 3'd2, 7'h00, 1'b1, 64'h200, 64'd77, 64'd8);
        MemReadEnE = 1; MemtoRegE = 1; RegWriteEnE = 1; LoadSizeE = 2'b10; tick();
        chk("lw_addr", ALUResultM, 64'h208);
        chk("lw_ctrl", {61'd0, MemReadEnM, MemtoRegM, RegWriteEnM}, 64'd7);
        chk("lw_size", {62'd0, LoadSizeM}, 64'd2);
        op(3'b010, 3'd2, 7'h00, 1'b1, 64'h400, 64'd12345, 64'd8);
        MemWriteEnE = 1; MemSizeE = 2'b10; tick();
        chk("sw_addr", ALUResultM, 64'h408);
        chk("sw_data", ReadData2M, 64'd12345);
        chk("sw_ctrl", {61'd0, MemWriteEnM, MemSizeM}, 64'd6);
        op(3'b011, 3'd0, 7'h00, 1'b1, 64'h200, 64'd0, 64'd8);
        JALE = 1; RegWriteEnE = 1; PCPlus4E = 64'h1008; RdE = 5'd0; tick();
        chk("jalr_tgt", ALUResultM, 64'h208);
        chk("jalr_jal", {63'd0, JALM}, 64'd1);
        chk("jalr_pc", PcPlus4M, 64'h1008);
        chk("jalr_rd0", {59'd0, RdM}, 64'd0);

        // asynchronous reset mid-run: outputs clear before the next edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_alu", ALUResultM, 64'd0);
        chk("arst_pc", PcPlus4M, 64'd0);
        chk("arst_jal", {63'd0, JALM}, 64'd0);
        tick();
        rst = 1'b0;

        // branch / lui / unused class
        op(3'b101, 3'd0, 7'h00, 1'b0, 64'd10, 64'd10, 64'h40); tick();
        chk("beq", ALUResultM, 64'd0);
        op(3'b101, 3'd1, 7'h00, 1'b0, 64'd1, 64'd2, 64'h40); tick();
        chk("bne", ALUResultM, 64'hFFFFFFFFFFFFFFFF);
        op(3'b111, 3'd0, 7'h00, 1'b1, 64'h12345678, 64'd0, 64'hFFFF); tick();
        chk("lui", ALUResultM, 64'hFFFF000);
        op(3'b110, 3'd0, 7'h00, 1'b0, 64'd5, 64'd6, 64'd7); tick();
        chk("op110", ALUResultM, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
